// File: rtl/packet_resizer_v2.sv
`default_nettype none
// ============================================================================
// Module   : packet_resizer_v2
// Purpose  : Re-frames an AXI-stream sample stream into output packets of a
//            programmable sample count and regenerates the CHDR header on
//            tuser (timestamp, seqnum, dst SID, EOB flush, pass-through).
// Revision : 1.0 - initial release
// ============================================================================
module packet_resizer_v2 #(
   parameter int          WIDTH            = 32,
   parameter int          SR_PKT_SIZE      = 129,
   parameter logic [15:0] DEFAULT_PKT_SIZE = 16'd256,
   parameter logic [15:0] TICKS_PER_SAMPLE = 16'd1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clear,
   input  logic [15:0]        next_dst_sid,
   input  logic               set_stb,
   input  logic [7:0]         set_addr,
   input  logic [31:0]        set_data,
   input  logic [WIDTH-1:0]   i_tdata,
   input  logic [127:0]       i_tuser,
   input  logic               i_tlast,
   input  logic               i_tvalid,
   output logic               i_tready,
   output logic [WIDTH-1:0]   o_tdata,
   output logic [127:0]       o_tuser,
   output logic               o_tlast,
   output logic               o_tvalid,
   input  logic               o_tready
);

   localparam logic [7:0] c_SR_ADDR = SR_PKT_SIZE[7:0];
   localparam int         c_EW      = WIDTH + 129;

   // Settings and framing state
   logic [15:0] r_pkt_size, r_active_size, r_cnt;
   logic [63:0] r_in_off, r_in_time;
   logic        r_in_has_time, r_in_first;
   logic [11:0] r_seq;

   // Header latched at the start of each output packet
   logic        r_h_has, r_eob_seen;
   logic [15:0] r_h_src, r_h_dst;
   logic [63:0] r_h_ts;
   logic [11:0] r_h_seq;

   // Two-entry output buffer; entry 0 drives the outputs directly
   logic [c_EW-1:0] r_e0, r_e1;
   logic            r_v0, r_v1;

   logic            w_push, w_pop, w_wr, w_first, w_cnt0, w_pass, w_last;
   logic            w_has, w_in_eob, w_eob_out;
   logic [15:0]     w_cnt, w_size_new, w_act;
   logic [11:0]     w_seq;
   logic [63:0]     w_off, w_ts;
   logic [127:0]    w_user;
   logic [c_EW-1:0] w_new;
   logic            w_unused;

   assign i_tready = !r_v1;
   assign o_tvalid = r_v0;
   assign o_tdata  = r_e0[WIDTH-1:0];
   assign o_tuser  = r_e0[WIDTH +: 128];
   assign o_tlast  = r_e0[c_EW-1];

   assign w_push = i_tvalid && i_tready;
   assign w_pop  = r_v0 && o_tready;

   // clear acts in the same cycle, so the concurrent beat starts fresh packets
   assign w_first    = r_in_first || clear;
   assign w_cnt0     = (r_cnt == 16'd0) || clear;
   assign w_cnt      = clear ? 16'd0 : r_cnt;
   assign w_seq      = clear ? 12'd0 : r_seq;
   assign w_wr       = set_stb && (set_addr == c_SR_ADDR);
   assign w_size_new = w_wr ? set_data[15:0] : r_pkt_size;
   assign w_act      = w_cnt0 ? w_size_new : r_active_size;
   assign w_pass     = (w_act == 16'd0);
   assign w_in_eob   = i_tuser[124];

   // Offset of this beat relative to the first sample of its input packet
   assign w_off = w_first ? 64'd0 : (r_in_off + {48'd0, TICKS_PER_SAMPLE});
   assign w_ts  = w_first ? i_tuser[63:0] : (r_in_time + w_off);
   assign w_has = w_first ? i_tuser[125] : r_in_has_time;

   // eob is sticky within an output packet and seen on the current beat too
   assign w_eob_out = (!w_cnt0 && r_eob_seen) || w_in_eob;

   assign w_last = w_pass ? i_tlast
                          : ((w_cnt == (w_act - 16'd1)) || (i_tlast && w_in_eob));

   // Build the header for the beat being accepted
   always_comb begin
      w_user = '0;
      if (w_pass) begin
         w_user = {i_tuser[127:124], w_seq, 16'd0, i_tuser[95:80],
                   next_dst_sid, i_tuser[63:0]};
      end else if (w_cnt0) begin
         w_user = {2'b00, w_has, w_eob_out, w_seq, 16'd0, i_tuser[95:80],
                   next_dst_sid, w_ts};
      end else begin
         w_user = {2'b00, r_h_has, w_eob_out, r_h_seq, 16'd0, r_h_src,
                   r_h_dst, r_h_ts};
      end
   end

   assign w_new    = {w_last, w_user, i_tdata};
   assign w_unused = ^{set_data[31:16], i_tuser[123:96], i_tuser[79:64]};

   // Packet-size settings register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  r_pkt_size <= DEFAULT_PKT_SIZE;
      else if (w_wr) r_pkt_size <= set_data[15:0];
   end

   // Framing counters, input timing and output header capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_active_size <= DEFAULT_PKT_SIZE;
         r_cnt         <= 16'd0;
         r_seq         <= 12'd0;
         r_in_first    <= 1'b1;
         r_in_off      <= 64'd0;
         r_in_time     <= 64'd0;
         r_in_has_time <= 1'b0;
         r_h_has       <= 1'b0;
         r_h_src       <= 16'd0;
         r_h_dst       <= 16'd0;
         r_h_ts        <= 64'd0;
         r_h_seq       <= 12'd0;
         r_eob_seen    <= 1'b0;
      end else if (w_push) begin
         r_in_first <= i_tlast;
         r_in_off   <= w_off;
         if (w_first) begin
            r_in_time     <= i_tuser[63:0];
            r_in_has_time <= i_tuser[125];
         end
         if (w_cnt0) begin
            r_active_size <= w_size_new;
            r_h_has       <= w_has;
            r_h_src       <= i_tuser[95:80];
            r_h_dst       <= next_dst_sid;
            r_h_ts        <= w_ts;
            r_h_seq       <= w_seq;
         end
         r_eob_seen <= w_last ? 1'b0 : w_eob_out;
         r_cnt      <= w_last ? 16'd0 : (w_cnt + 16'd1);
         r_seq      <= w_last ? (w_seq + 12'd1) : w_seq;
      end else if (clear) begin
         r_cnt      <= 16'd0;
         r_seq      <= 12'd0;
         r_in_first <= 1'b1;
      end
   end

   // Output buffer: head holds the presented beat, second entry absorbs a stall
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_v0 <= 1'b0;
         r_v1 <= 1'b0;
         r_e0 <= '0;
         r_e1 <= '0;
      end else if (w_pop) begin
         if (r_v1) begin
            r_e0 <= r_e1;
            r_v1 <= 1'b0;
         end else if (w_push) begin
            r_e0 <= w_new;
         end else begin
            r_v0 <= 1'b0;
         end
      end else if (w_push) begin
         if (r_v0) begin
            r_e1 <= w_new;
            r_v1 <= 1'b1;
         end else begin
            r_e0 <= w_new;
            r_v0 <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_packet_resizer_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_resizer_v2
// Purpose  : Randomised scoreboard bench for packet_resizer_v2 with a
//            packet-level reference model of the re-framing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_resizer_v2;

   localparam int W   = 32;
   localparam int SR  = 129;
   localparam int TPS = 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          clear = 1'b0;
   logic [15:0]   next_dst_sid = 16'hD00D;
   logic          set_stb = 1'b0;
   logic [7:0]    set_addr = 8'd0;
   logic [31:0]   set_data = 32'd0;
   logic [W-1:0]  i_tdata = '0;
   logic [127:0]  i_tuser = '0;
   logic          i_tlast = 1'b0;
   logic          i_tvalid = 1'b0;
   logic          i_tready;
   logic [W-1:0]  o_tdata;
   logic [127:0]  o_tuser;
   logic          o_tlast;
   logic          o_tvalid;
   logic          o_tready = 1'b1;

   packet_resizer_v2 #(.WIDTH(W), .SR_PKT_SIZE(SR), .DEFAULT_PKT_SIZE(16'd256),
                       .TICKS_PER_SAMPLE(16'(TPS))) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .next_dst_sid(next_dst_sid),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast),
      .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
      .o_tvalid(o_tvalid), .o_tready(o_tready));

   always #5 clk = ~clk;

   typedef struct packed {
      logic         l;
      logic [127:0] u;
      logic [W-1:0] d;
   } beat_t;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   int    occ      = 0;
   int    rdy_pct  = 100;
   int    vld_pct  = 100;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   logic [15:0] m_pkt;
   logic        m_in_first;
   logic [63:0] m_in_time;
   logic        m_in_has;
   logic [63:0] m_idx;
   int          m_cnt, m_act;
   logic [11:0] m_seq, m_oseq;
   logic [15:0] m_src, m_dst;
   logic        m_hhas, m_eob;
   logic [63:0] m_ts;

   task automatic model_reset();
      m_pkt = 16'd256; m_act = 256; m_in_first = 1'b1; m_cnt = 0; m_seq = 12'd0;
      m_idx = 64'd0; m_eob = 1'b0;
   endtask

   task automatic model_clear();
      m_cnt = 0; m_seq = 12'd0; m_in_first = 1'b1;
   endtask

   // One accepted input beat -> one expected output beat
   task automatic model_accept();
      beat_t e;
      logic  eob, last;
      eob = i_tuser[124];
      if (m_in_first) begin
         m_in_time = i_tuser[63:0]; m_in_has = i_tuser[125]; m_idx = 64'd0;
      end else begin
         m_idx = m_idx + 64'd1;
      end
      if (m_cnt == 0) begin
         m_act  = (set_stb && set_addr == 8'(SR)) ? int'(set_data[15:0]) : int'(m_pkt);
         m_src  = i_tuser[95:80];
         m_dst  = next_dst_sid;
         m_hhas = m_in_has;
         m_ts   = m_in_time + m_idx * 64'(TPS);
         m_oseq = m_seq;
         m_eob  = 1'b0;
      end
      if (m_act == 0) begin
         last = i_tlast;
         e.u  = {i_tuser[127:124], m_seq, 16'h0, i_tuser[95:80], next_dst_sid, i_tuser[63:0]};
      end else begin
         last  = (m_cnt + 1 == m_act) || (i_tlast && eob);
         m_eob = m_eob | eob;
         e.u   = {2'b00, m_hhas, m_eob, m_oseq, 16'h0, m_src, m_dst, m_ts};
      end
      e.d = i_tdata;
      e.l = last;
      exp_q.push_back(e);
      if (last) begin m_cnt = 0; m_seq = m_seq + 12'd1; end
      else m_cnt++;
      m_in_first = i_tlast;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick(output bit acc);
      @(negedge clk);
      acc = i_tvalid && i_tready && reset_n;
      if (clear) model_clear();
      if (acc) model_accept();
      if (set_stb && set_addr == 8'(SR)) m_pkt = set_data[15:0];
      @(posedge clk); #1;
      set_stb  = 1'b0;
      clear    = 1'b0;
      o_tready = ($urandom_range(99) < rdy_pct);
   endtask

   task automatic send_beat(input logic [W-1:0] d, input logic [127:0] u, input logic l);
      bit acc;
      acc = 1'b0;
      i_tdata = d; i_tuser = u; i_tlast = l;
      for (int k = 0; k < 2000 && !acc; k++) begin
         i_tvalid = ($urandom_range(99) < vld_pct);
         tick(acc);
      end
      i_tvalid = 1'b0;
      if (!acc) begin
         n_checks++;
         $display("FAIL send_timeout: got no acceptance required acceptance within 2000 cycles");
      end
   endtask

   task automatic write_size(input logic [15:0] v);
      bit acc;
      set_stb = 1'b1; set_addr = 8'(SR); set_data = {16'hA5A5, v};
      tick(acc);
   endtask

   task automatic send_pkt(input int len, input logic eob, input logic has,
                           input logic [63:0] ts, input int wr_at, input logic [15:0] wr_val,
                           input int clr_at);
      logic [127:0] u;
      u = {2'b00, has, eob, 12'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), ts};
      for (int i = 0; i < len; i++) begin
         if (i == wr_at) begin
            set_stb = 1'b1; set_addr = 8'(SR); set_data = {16'h5A5A, wr_val};
         end
         if (i == clr_at) clear = 1'b1;
         send_beat(W'($urandom), u, i == len - 1);
      end
   endtask

   task automatic drain();
      bit acc;
      i_tvalid = 1'b0;
      for (int k = 0; k < 5000 && (exp_q.size() != 0 || occ != 0); k++) tick(acc);
      if (exp_q.size() != 0 || occ != 0) begin
         n_checks++;
         $display("FAIL drain_timeout: got %0d beats pending required 0", exp_q.size());
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      beat_t prev, cur, e;
      bit    prev_stall;
      prev_stall = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_stall = 1'b0;
         end else begin
            chk("i_tready_vs_fill", 192'(i_tready), 192'(occ < 2));
            chk("o_tvalid_vs_fill", 192'(o_tvalid), 192'(occ > 0));
            cur = {o_tlast, o_tuser, o_tdata};
            if (prev_stall && o_tvalid) chk("stall_hold", 192'(cur), 192'(prev));
            if (o_tvalid && o_tready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL extra_beat: got beat %h required none", cur);
               end else begin
                  e = exp_q.pop_front();
                  chk("o_tdata", 192'(o_tdata), 192'(e.d));
                  chk("o_tuser", 192'(o_tuser), 192'(e.u));
                  chk("o_tlast", 192'(o_tlast), 192'(e.l));
               end
            end
            prev_stall = o_tvalid && !o_tready;
            prev = cur;
            occ = occ + int'(i_tvalid && i_tready) - int'(o_tvalid && o_tready);
         end
      end
   end

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: got simulation still running required completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int total;
      bit acc;
      model_reset();
      #23;
      chk("rst_o_tvalid", 192'(o_tvalid), 192'(0));
      chk("rst_o_tlast",  192'(o_tlast),  192'(0));
      chk("rst_o_tdata",  192'(o_tdata),  192'(0));
      chk("rst_o_tuser",  192'(o_tuser),  192'(0));
      chk("rst_i_tready", 192'(i_tready), 192'(1));
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Steady resize: 10 samples at t=1000 with size 4, then more input
      write_size(16'd4);
      send_pkt(10, 1'b0, 1'b1, 64'd1000, -1, 16'd0, -1);
      send_pkt(6, 1'b0, 1'b1, 64'd5000, -1, 16'd0, -1);
      drain();

      // EOB flush: short 5-sample packet with size 8
      write_size(16'd8);
      send_pkt(5, 1'b1, 1'b1, 64'd7777, -1, 16'd0, -1);
      drain();

      // Pass-through
      next_dst_sid = 16'hBEEF;
      write_size(16'd0);
      send_pkt(3, 1'b0, 1'b1, 64'd42, -1, 16'd0, -1);
      send_pkt(7, 1'b0, 1'b0, 64'd99, -1, 16'd0, -1);
      drain();

      // Mid-packet size write
      vld_pct = 70;
      write_size(16'd4);
      send_pkt(10, 1'b0, 1'b1, 64'd2000, 1, 16'd2, -1);
      send_pkt(4, 1'b0, 1'b1, 64'd3000, -1, 16'd0, -1);
      drain();

      // Backpressure with random framing, eob, size writes, clears, ts wrap
      rdy_pct = 30; vld_pct = 80; total = 0;
      while (total < 1000) begin
         int len;
         len = $urandom_range(20, 1);
         next_dst_sid = 16'($urandom);
         send_pkt(len, ($urandom_range(99) < 20), 1'($urandom),
                  ($urandom_range(9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFD : {$urandom, $urandom},
                  ($urandom_range(9) == 0) ? int'($urandom_range(len - 1)) : -1,
                  16'($urandom_range(6)),
                  ($urandom_range(29) == 0) ? int'($urandom_range(len - 1)) : -1);
         total += len;
      end
      drain();

      // Sequence wrap: one-sample packets, more than 4096 of them
      rdy_pct = 100; vld_pct = 100;
      write_size(16'd1);
      for (int p = 0; p < 82; p++) send_pkt(50, 1'b0, 1'b1, 64'(p * 100), -1, 16'd0, -1);
      drain();

      // Asynchronous reset mid-packet with beats buffered
      write_size(16'd4);
      rdy_pct = 0;
      tick(acc);
      send_beat(W'($urandom), {4'b0010, 124'd5}, 1'b0);
      send_beat(W'($urandom), {4'b0010, 124'd5}, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_o_tvalid", 192'(o_tvalid), 192'(0));
      chk("async_rst_i_tready", 192'(i_tready), 192'(1));
      chk("async_rst_o_tuser",  192'(o_tuser),  192'(0));
      exp_q.delete();
      occ = 0;
      model_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;
      rdy_pct = 100;
      send_pkt(5, 1'b1, 1'b1, 64'd123, -1, 16'd0, -1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
